ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of first fetch after reset.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries; only the value 2 is supported.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rom_addr  out  32  byte address presented to the instruction ROM (ROM read is combinational, word index = addr/4).
REQ-006 rom_data  in  32  instruction word returned by the ROM in the same cycle.
REQ-007 redir_valid  in  1  branch/jump redirect request from execute.
REQ-008 redir_pc  in  32  redirect target byte address.
REQ-009 out_valid  out  1  buffer head holds a valid instruction.
REQ-010 out_ready  in  1  decode accepts the head this cycle.
REQ-011 out_instr  out  32  head instruction word.
REQ-012 out_pc  out  32  byte address of the head instruction.
REQ-013 fault  out  1  sticky misaligned-redirect indication.

Function
REQ-014 FSM states: RUN, FAULT; reset enters RUN; RUN->FAULT on accepted redirect with redir_pc[1:0] != 0; FAULT exits only by rst.
REQ-015 rom_addr SHALL equal the fetch PC register at all times (including FAULT).
REQ-016 Pop occurs when out_valid && out_ready; out_instr/out_pc SHALL be stable while out_valid && !out_ready.
REQ-017 Fetch occurs in RUN when !redir_valid and (count < 2 or pop); fetch writes {rom_data, rom_addr} into the buffer tail and sets PC <= PC + 4.
REQ-018 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no fault.
REQ-019 Latency: instruction at address A appears on out_* exactly one cycle after rom_addr == A with fetch asserted.
REQ-020 Buffer is FIFO ordered; simultaneous pop and fetch when count == 2 keeps count == 2; pop and fetch at count == 1 keeps count == 1.
REQ-021 Redirect has priority over fetch: on redir_valid in RUN the buffer is flushed (count <= 0), PC <= redir_pc, no write that cycle.
REQ-022 A pop coinciding with redirect SHALL count as consumed by decode; flushed entries are discarded without handshake.
REQ-023 Misaligned redirect: buffer flushed, PC unchanged, fault <= 1, state <= FAULT.
REQ-024 In FAULT: out_valid = 0, no fetch, redir_valid ignored, fault = 1.
REQ-025 out_valid = (count != 0) in RUN.

Reset
REQ-026 On rst: PC <= RESET_PC, count <= 0, state <= RUN, fault <= 0, buffer pointers <= 0.
REQ-027 Reset outputs: out_valid = 0, fault = 0, rom_addr = RESET_PC, out_instr = 32'h0000_0013 (NOP), out_pc = RESET_PC.
REQ-028 rst asserted mid-operation SHALL override redirect, fetch and pop in that cycle; no buffered instruction survives.
REQ-029 out_instr/out_pc SHALL read NOP/RESET_PC whenever count == 0.

Structure
REQ-030 Package ifetch_pkg SHALL hold: XLEN = 32, INSTR_NOP = 32'h0000_0013, fetch state enum {RUN, FAULT}, buffer entry struct {instr, pc}.
REQ-031 Buffer SHALL be sub-module ifetch_buf (2-entry FIFO, push/pop/flush, count, head outputs); PC, FSM and fault logic stay in ifetch.
REQ-032 No combinational path from out_ready or redir_valid to rom_addr.

Verification
REQ-033 Reset, out_ready=1, ROM word 1 = 32'h02A00093 -> cycle 1 out_pc=0 instr=0, cycle 2 out_pc=4 instr=32'h02A00093, one instr per cycle.
REQ-034 out_ready=0 for 5 cycles after reset -> count saturates at 2, rom_addr holds 8, out_pc stays 0; release -> out_pc 0,4,8 in consecutive cycles, none lost or duplicated.
REQ-035 redir_valid with redir_pc=32'h14 while count=2 -> next cycle out_valid=0, rom_addr=32'h14; following cycle out_pc=32'h14.
REQ-036 redir_pc=32'h16 -> fault=1 next cycle, out_valid=0 and rom_addr frozen for 10 cycles, later redir_valid ignored; rst clears fault, rom_addr=RESET_PC.
REQ-037 Redirect to 32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004, fault stays 0.
REQ-038 rst asserted while count=2 and redir_valid=1 -> next cycle out_valid=0, rom_addr=RESET_PC, fault=0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package ifetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } buf_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry instruction FIFO with push/pop/flush and a NOP-filled head when empty.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  buf_entry_t      i_wdata,
  output logic [1:0]      o_count,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  buf_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Storage, pointers and occupancy; flush discards all entries (a coinciding pop is simply absorbed).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '{instr: INSTR_NOP, pc: RESET_PC};
      r_mem[1] <= '{instr: INSTR_NOP, pc: RESET_PC};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: an empty buffer shows a NOP at the reset address.
  always_comb begin
    o_instr = INSTR_NOP;
    o_pc    = RESET_PC;
    if (r_count != 2'd0) begin
      o_instr = r_mem[r_rd_ptr].instr;
      o_pc    = r_mem[r_rd_ptr].pc;
    end else begin
      o_instr = INSTR_NOP;
      o_pc    = RESET_PC;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, redirect/fault FSM and a 2-deep fetch buffer.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [XLEN-1:0] o_rom_addr,
  input  logic [XLEN-1:0] i_rom_data,
  input  logic            i_redir_valid,
  input  logic [XLEN-1:0] i_redir_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_instr,
  output logic [XLEN-1:0] o_out_pc,
  output logic            o_fault
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;

  logic [1:0]      w_count;
  logic            w_run;
  logic            w_pop;
  logic            w_redir;
  logic            w_misalign;
  logic            w_fetch;
  buf_entry_t      w_wdata;

  assign w_run      = (r_state == RUN);
  assign o_out_valid = w_run && (w_count != 2'd0);
  assign w_pop      = o_out_valid && i_out_ready;
  assign w_redir    = w_run && i_redir_valid;
  assign w_misalign = w_redir && (i_redir_pc[1:0] != 2'b00);
  assign w_fetch    = w_run && !i_redir_valid &&
                      ((w_count != BUF_DEPTH[1:0]) || w_pop);
  assign w_wdata    = '{instr: i_rom_data, pc: r_pc};

  // The ROM address is the PC register itself, so no input reaches it combinationally.
  assign o_rom_addr = r_pc;
  assign o_fault    = r_fault;

  // PC, state and sticky fault: redirect beats fetch; a misaligned target freezes everything until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_misalign) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else if (w_redir) begin
            r_pc <= i_redir_pc;
          end else if (w_fetch) begin
            r_pc <= r_pc + 32'd4;
          end else begin
            r_pc <= r_pc;
          end
        end
        FAULT: begin
          r_state <= FAULT;
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  ifetch_buf #(
    .RESET_PC (RESET_PC)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_fetch),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_wdata (w_wdata),
    .o_count (w_count),
    .o_instr (o_out_instr),
    .o_pc    (o_out_pc)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch with a small combinational ROM.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int checks;
  int failures;

  ifetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .i_redir_valid (redir_valid),
    .i_redir_pc    (redir_pc),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_instr   (out_instr),
    .o_out_pc      (out_pc),
    .o_fault       (fault)
  );

  // ROM contents: word 0 = 0, word 1 = addi x1,x0,42, otherwise a tag of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h0000_0000;
    else if (a == 32'h0000_0004) return 32'h02A0_0093;
    else                         return 32'hC000_0000 | a;
  endfunction

  assign rom_data = rom_word(rom_addr);

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    out_ready   = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    tick();
    tick();

    // Reset state
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_addr", rom_addr, 32'h0);
    check("rst_instr", out_instr, 32'h0000_0013);
    check("rst_pc", out_pc, 32'h0);

    // Streaming with decode always ready
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("s_valid1", {31'd0, out_valid}, 32'd1);
    check("s_pc1", out_pc, 32'h0);
    check("s_instr1", out_instr, 32'h0);
    tick();
    check("s_pc2", out_pc, 32'h4);
    check("s_instr2", out_instr, 32'h02A0_0093);
    tick();
    check("s_pc3", out_pc, 32'h8);
    check("s_instr3", out_instr, 32'hC000_0008);

    // Back-pressure: buffer fills, PC stalls, head stays put
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_pc_hold", out_pc, 32'h0);
    end
    check("bp_addr", rom_addr, 32'h8);
    check("bp_instr", out_instr, 32'h0);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_rel1", out_pc, 32'h4);
    tick();
    check("bp_rel2", out_pc, 32'h8);
    tick();
    check("bp_rel3", out_pc, 32'hC);

    // Redirect with full buffer
    out_ready = 1'b0;
    tick();
    redir_valid = 1'b1; redir_pc = 32'h14;
    tick();
    redir_valid = 1'b0;
    check("rd_valid0", {31'd0, out_valid}, 32'd0);
    check("rd_addr", rom_addr, 32'h14);
    check("rd_empty_pc", out_pc, 32'h0);
    check("rd_empty_instr", out_instr, 32'h0000_0013);
    tick();
    check("rd_valid1", {31'd0, out_valid}, 32'd1);
    check("rd_pc", out_pc, 32'h14);
    check("rd_instr", out_instr, 32'hC000_0014);

    // Redirect to top of address space: PC wraps without fault
    out_ready = 1'b1;
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    check("wr_addr", rom_addr, 32'hFFFF_FFFC);
    tick();
    check("wr_pc0", out_pc, 32'hFFFF_FFFC);
    tick();
    check("wr_pc1", out_pc, 32'h0);
    tick();
    check("wr_pc2", out_pc, 32'h4);
    check("wr_instr2", out_instr, 32'h02A0_0093);
    check("wr_fault", {31'd0, fault}, 32'd0);

    // Reset overrides a simultaneous redirect with a full buffer
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1; redir_valid = 1'b1; redir_pc = 32'h40; out_ready = 1'b1;
    tick();
    rst = 1'b0; redir_valid = 1'b0;
    check("rr_valid", {31'd0, out_valid}, 32'd0);
    check("rr_addr", rom_addr, 32'h0);
    check("rr_fault", {31'd0, fault}, 32'd0);
    check("rr_pc", out_pc, 32'h0);

    // Misaligned redirect: sticky fault, frozen fetch, later redirects ignored
    tick();
    tick();
    check("mf_pre_addr", rom_addr, 32'h8);
    redir_valid = 1'b1; redir_pc = 32'h16;
    tick();
    redir_valid = 1'b0;
    check("mf_fault", {31'd0, fault}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mf_valid", {31'd0, out_valid}, 32'd0);
      check("mf_addr", rom_addr, 32'h8);
    end
    redir_valid = 1'b1; redir_pc = 32'h20;
    tick();
    redir_valid = 1'b0;
    check("mf_ign_addr", rom_addr, 32'h8);
    check("mf_ign_fault", {31'd0, fault}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mf_clr_fault", {31'd0, fault}, 32'd0);
    check("mf_clr_addr", rom_addr, 32'h0);
    tick();
    check("mf_resume", out_pc, 32'h0);
    check("mf_resume_v", {31'd0, out_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
